// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES-128 round-key store.
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int NUM_RK     = 11;
    localparam int IDX_W      = 4;
    localparam int AES_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_PLAY  = 2'd3
    } rks_state_t;

endpackage

// File: rtl/rk_mem.sv
// Round-key register file: one write port, one registered read port.
// Storage has no reset; only the read register clears so rk_out starts at zero.
module rk_mem #(
    parameter int KEY_W  = 128,
    parameter int NUM_RK = 11,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [KEY_W-1:0] rdata
);

    logic [KEY_W-1:0] mem [NUM_RK];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/aes_round_key_store.sv
// Captures the 11 expanded AES-128 round keys once and replays them forward
// (encrypt) or reverse (decrypt) to the AddRoundKey datapath.
import aes_pkg::*;

module aes_round_key_store (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             wr_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic             wr_ready,
    output logic             keys_valid,
    output logic             wr_overflow,
    input  logic             rd_start,
    input  logic             inv_en,
    input  logic             rd_next,
    output logic [KEY_W-1:0] rk_out,
    output logic             rk_valid,
    output logic [IDX_W-1:0] rk_round,
    output logic             rk_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

    // Handshake: a key is written on any cycle where wr_valid && wr_ready;
    // wr_ready depends only on state, never on wr_valid.
    rks_state_t       state, state_n;
    logic [IDX_W-1:0] wr_ptr, wr_ptr_n;
    logic [IDX_W-1:0] rd_ptr, rd_ptr_n;
    logic             inv_q, inv_n;
    logic             rk_valid_q, rk_valid_n;
    logic             keys_valid_q, keys_valid_n;
    logic             ovf_q, ovf_n;
    logic             mem_we, mem_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_EMPTY;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inv_q        <= 1'b0;
            rk_valid_q   <= 1'b0;
            keys_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            inv_q        <= inv_n;
            rk_valid_q   <= rk_valid_n;
            keys_valid_q <= keys_valid_n;
            ovf_q        <= ovf_n;
        end
    end

    always_comb begin
        state_n      = state;
        wr_ptr_n     = wr_ptr;
        rd_ptr_n     = rd_ptr;
        inv_n        = inv_q;
        rk_valid_n   = rk_valid_q;
        keys_valid_n = keys_valid_q;
        ovf_n        = ovf_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;

        if (wr_valid && state != ST_LOAD) begin
            ovf_n = 1'b1;
        end
        if (load_start) begin
            ovf_n = 1'b0;
        end

        case (state)
            ST_EMPTY: begin
                if (load_start) begin
                    state_n  = ST_LOAD;
                    wr_ptr_n = '0;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    wr_ptr_n = '0;
                end else if (wr_valid) begin
                    mem_we = 1'b1;
                    if (wr_ptr == LAST_IDX) begin
                        state_n      = ST_READY;
                        keys_valid_n = 1'b1;
                        wr_ptr_n     = '0;
                    end else begin
                        wr_ptr_n = wr_ptr + 1'b1;
                    end
                end
            end
            ST_READY, ST_PLAY: begin
                if (load_start) begin
                    state_n      = ST_LOAD;
                    keys_valid_n = 1'b0;
                    rk_valid_n   = 1'b0;
                    wr_ptr_n     = '0;
                end else if (rd_start) begin
                    state_n    = ST_PLAY;
                    inv_n      = inv_en;
                    rd_ptr_n   = inv_en ? LAST_IDX : '0;
                    rk_valid_n = 1'b1;
                    mem_re     = 1'b1;
                end else if (state == ST_PLAY && rd_next && rk_valid_q) begin
                    if (rk_last) begin
                        state_n    = ST_READY;
                        rk_valid_n = 1'b0;
                    end else begin
                        // rk_last guards both ends, so the step never leaves 0..LAST_IDX
                        rd_ptr_n = inv_q ? rd_ptr - 1'b1 : rd_ptr + 1'b1;
                        mem_re   = 1'b1;
                    end
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    rk_mem #(
        .KEY_W (KEY_W),
        .NUM_RK(NUM_RK),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .waddr(wr_ptr),
        .wdata(key_in),
        .re   (mem_re),
        .raddr(rd_ptr_n),
        .rdata(rk_out)
    );

    assign wr_ready    = (state == ST_LOAD);
    assign keys_valid  = keys_valid_q;
    assign wr_overflow = ovf_q;
    assign rk_valid    = rk_valid_q;
    assign rk_round    = rd_ptr;
    assign rk_last     = rk_valid_q && (inv_q ? (rd_ptr == '0) : (rd_ptr == LAST_IDX));

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed bench for aes_round_key_store using the FIPS-197 AES-128 key schedule.
module tb_aes_round_key_store;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_start;
  logic         wr_valid;
  logic [127:0] key_in;
  logic         wr_ready;
  logic         keys_valid;
  logic         wr_overflow;
  logic         rd_start;
  logic         inv_en;
  logic         rd_next;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic         rk_last;

  logic [127:0] rk_tab [11];
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  aes_round_key_store dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .key_in     (key_in),
    .wr_ready   (wr_ready),
    .keys_valid (keys_valid),
    .wr_overflow(wr_overflow),
    .rd_start   (rd_start),
    .inv_en     (inv_en),
    .rd_next    (rd_next),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rk_round   (rk_round),
    .rk_last    (rk_last)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    check("load_wr_ready", wr_ready, 1);
    check("load_keys_valid_clr", keys_valid, 0);
    for (int i = 0; i < 11; i++) begin
      wr_valid = 1'b1;
      key_in   = rk_tab[i];
      cyc();
      if (i < 10) check("load_mid_keys_valid", keys_valid, 0);
    end
    wr_valid = 1'b0;
    key_in   = '0;
    check("load_done_keys_valid", keys_valid, 1);
    check("load_done_wr_ready", wr_ready, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_keys_valid"}, keys_valid, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_wr_overflow"}, wr_overflow, 0);
    check({tag, "_rk_valid"}, rk_valid, 0);
    check({tag, "_rk_last"}, rk_last, 0);
    check({tag, "_rk_round"}, rk_round, 0);
    check({tag, "_rk_out"}, rk_out, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // clock / reset
    rst = 1'b1; load_start = 1'b0; wr_valid = 1'b0; key_in = '0;
    rd_start = 1'b0; inv_en = 1'b0; rd_next = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    check_reset_outputs("reset");

    // rd_start before any load is ignored
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    check("empty_rd_start_rk_valid", rk_valid, 0);

    load_keys();

    // forward playback, rd_next every cycle
    inv_en = 1'b0; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0; rd_next = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      check("fwd_rk_valid", rk_valid, 1);
      check("fwd_rk_round", rk_round, r);
      check("fwd_rk_out", rk_out, rk_tab[r]);
      check("fwd_rk_last", rk_last, (r == 10));
      cyc();
    end
    rd_next = 1'b0;
    check("fwd_end_rk_valid", rk_valid, 0);
    check("fwd_end_rk_last", rk_last, 0);
    check("fwd_end_keys_valid", keys_valid, 1);

    // reverse playback, two idle cycles between advances
    inv_en = 1'b1; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0; inv_en = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      check("rev_rk_valid", rk_valid, 1);
      check("rev_rk_round", rk_round, r);
      check("rev_rk_out", rk_out, rk_tab[r]);
      check("rev_rk_last", rk_last, (r == 0));
      cyc(); cyc();
      check("rev_hold_rk_out", rk_out, rk_tab[r]);
      check("rev_hold_rk_round", rk_round, r);
      rd_next = 1'b1;
      cyc();
      rd_next = 1'b0;
    end
    check("rev_end_rk_valid", rk_valid, 0);

    // stray write in READY sets the sticky overflow and leaves key 10 intact
    wr_valid = 1'b1; key_in = '1;
    cyc();
    wr_valid = 1'b0; key_in = '0;
    check("ovf_set", wr_overflow, 1);
    cyc();
    check("ovf_sticky", wr_overflow, 1);
    check("ovf_keys_valid", keys_valid, 1);
    inv_en = 1'b1; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0; inv_en = 1'b0;
    check("ovf_replay_key10", rk_out, rk_tab[10]);
    rd_next = 1'b1;
    cyc();
    rd_next = 1'b0;
    check("rev_step_key9", rk_out, rk_tab[9]);

    // rd_start during PLAY restarts in the newly sampled direction
    inv_en = 1'b0; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    check("restart_rk_out", rk_out, rk_tab[0]);
    check("restart_rk_round", rk_round, 0);

    // load_start aborts playback and clears overflow
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    check("abort_rk_valid", rk_valid, 0);
    check("abort_ovf_clr", wr_overflow, 0);
    check("abort_wr_ready", wr_ready, 1);
    check("abort_keys_valid", keys_valid, 0);
    for (int i = 0; i < 11; i++) begin
      wr_valid = 1'b1;
      key_in   = rk_tab[i];
      cyc();
    end
    wr_valid = 1'b0;
    check("reload_keys_valid", keys_valid, 1);

    // load_start beats rd_start in READY
    load_start = 1'b1; rd_start = 1'b1;
    cyc();
    load_start = 1'b0; rd_start = 1'b0;
    check("both_wr_ready", wr_ready, 1);
    check("both_keys_valid", keys_valid, 0);
    check("both_rk_valid", rk_valid, 0);
    cyc();
    check("both_rk_valid_hold", rk_valid, 0);
    load_keys();

    // reset at round 5 of forward playback
    inv_en = 1'b0; rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    rd_next = 1'b1;
    repeat (5) cyc();
    rd_next = 1'b0;
    check("pre_rst_rk_round", rk_round, 5);
    check("pre_rst_rk_out", rk_out, rk_tab[5]);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    check("post_rst_rd_ignored", rk_valid, 0);
    check("post_rst_rk_out", rk_out, 0);
    load_keys();
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    check("post_reload_rk_valid", rk_valid, 1);
    check("post_reload_rk_out", rk_out, rk_tab[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Stores all 11 AES-128 round keys (round 0..10) produced by the key-expansion stage, one key per write beat.
- Plays the keys back to the AddRoundKey datapath:
  - forward order 0..10 for encryption;
  - reverse order 10..0 for decryption (inv_en=1).
- The key schedule therefore runs once per key, not once per block.
- Sits between key expansion (upstream) and the round datapath (downstream).

Parameters:
- KEY_W, 128, round-key width in bits
- NUM_RK, 11, number of stored round keys
- IDX_W, 4, width of round index and pointers

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- load_start  input  1  pulse: discard stored keys, begin capture at index 0
- wr_valid  input  1  key_in valid this cycle
- key_in  input  KEY_W  round key from expansion, {w0,w1,w2,w3}, w0 in MSBs
- wr_ready  output  1  store accepts key_in this cycle
- keys_valid  output  1  all NUM_RK keys captured
- wr_overflow  output  1  sticky: write attempted while not capturing
- rd_start  input  1  pulse: begin a playback sequence
- inv_en  input  1  direction for rd_start: 0 forward, 1 reverse (sampled with rd_start only)
- rd_next  input  1  consumer advance to next key
- rk_out  output  KEY_W  current round key
- rk_valid  output  1  rk_out holds a valid key
- rk_round  output  IDX_W  logical round number of rk_out (0..10)
- rk_last  output  1  rk_out is the final key of the sequence

Behaviour:
- Reset (rst=1 at clk edge):
  - state=EMPTY; wr_ptr=0; rd_ptr=0;
  - keys_valid=0, wr_ready=0, wr_overflow=0;
  - rk_valid=0, rk_last=0, rk_round=0, rk_out=0.
  - Key RAM contents are don't-care, and keys_valid guards them.
  - Reset mid-capture or mid-playback aborts the operation immediately.
- States: EMPTY, LOAD, READY, PLAY.
- EMPTY:
  - wr_ready=0.
  - load_start -> LOAD, wr_ptr=0.
- LOAD:
  - wr_ready=1.
  - Each wr_valid stores key_in at mem[wr_ptr] and increments wr_ptr.
  - The write at wr_ptr=NUM_RK-1 -> READY, keys_valid=1 next cycle, wr_ptr wraps to 0.
  - load_start in LOAD restarts the capture at wr_ptr=0; a same-cycle wr_valid is dropped.
- READY:
  - wr_ready=0.
  - rd_start: latch direction and go to PLAY.
    - forward: rd_ptr=0;
    - reverse: rd_ptr=NUM_RK-1.
  - load_start -> LOAD and clears keys_valid.
  - If load_start and rd_start occur together, load_start wins.
- PLAY:
  - Registered read, 1-cycle latency: rk_valid=1 and rk_out=mem[start index] in the cycle after rd_start.
  - rk_round=rd_ptr.
  - rk_last=1 when rd_ptr=10 (forward) or rd_ptr=0 (reverse).
  - rd_next with rk_valid=1 and rk_last=0: step rd_ptr (+1 forward, -1 reverse); the new key appears the next cycle.
    - rk_valid stays 1 continuously, so back-to-back rd_next yields one key per cycle.
  - rd_next with rk_last=1: -> READY; rk_valid, rk_last=0 next cycle. Keys are retained for the next block.
  - Without rd_next, rk_out and rk_round hold.
  - rd_start during PLAY restarts the sequence from the start index using the new inv_en.
  - load_start during PLAY aborts playback (rk_valid=0 next cycle) -> LOAD.
- wr_overflow:
  - Set when wr_valid=1 in any state other than LOAD; the data is ignored.
  - Cleared only by rst or load_start.
- rd_start is ignored outside READY/PLAY; no output changes.
- Pointer arithmetic:
  - modulo-free, IDX_W bits, never exceeds NUM_RK-1;
  - reverse decrement never passes below 0.

Decomposition:
- Shared package aes_pkg:
  - KEY_W, NUM_RK, IDX_W;
  - state encoding for EMPTY/LOAD/READY/PLAY (2 bits);
  - AES_ROUNDS=10.
- One sub-module, rk_mem:
  - NUM_RK x KEY_W register file;
  - one write port, one registered read port;
  - no reset on contents.
- Control FSM and pointers stay in aes_round_key_store.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: load_start, 11 wr_valid beats of the expanded keys -> keys_valid=1 one cycle after the 11th beat; wr_ready=0 afterwards.
- Forward playback: rd_start (inv_en=0), rd_next every cycle:
  - rk_round 0..10, rk_out round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - rk_last only on round 10;
  - then READY.
- Reverse playback: rd_start (inv_en=1), rd_next with gaps of 2 idle cycles:
  - rk_out first = d014f9a8c9ee2589e13f0cc8b6630ca6, last = 2b7e151628aed2a6abf7158809cf4f3c;
  - outputs hold during the gaps.
- Extra wr_valid in READY -> wr_overflow=1, stored key 10 unchanged on replay; load_start clears wr_overflow.
- Simultaneous load_start+rd_start in READY -> LOAD entered, rk_valid stays 0, keys_valid=0.
- rst asserted at round 5 of playback:
  - next cycle all outputs at reset values;
  - rd_start ignored until a new full load completes.
